// File: rtl/hdmi_tmds_encoder_pkg.sv
`default_nettype none
// ============================================================================
// tmds_pkg : lane modes, fixed TMDS symbols and shared encode helpers
// Revision 1.0
// ============================================================================
package tmds_pkg;

   typedef enum logic [2:0] {
      MODE_CTRL   = 3'd0,
      MODE_VIDEO  = 3'd1,
      MODE_TERC4  = 3'd2,
      MODE_VGUARD = 3'd3,
      MODE_DGUARD = 3'd4
   } tmds_mode_e;

   localparam int         C_DISP_W      = 5;

   localparam logic [9:0] C_CTRL_00     = 10'b1101010100;
   localparam logic [9:0] C_CTRL_01     = 10'b0010101011;
   localparam logic [9:0] C_CTRL_10     = 10'b0101010100;
   localparam logic [9:0] C_CTRL_11     = 10'b1010101011;
   localparam logic [9:0] C_GUARD_EVEN  = 10'b1011001100;
   localparam logic [9:0] C_GUARD_ODD   = 10'b0100110011;

   function automatic tmds_mode_e norm_mode(input logic [2:0] m);
      tmds_mode_e r;
      case (m)
         3'd1:    r = MODE_VIDEO;
         3'd2:    r = MODE_TERC4;
         3'd3:    r = MODE_VGUARD;
         3'd4:    r = MODE_DGUARD;
         default: r = MODE_CTRL;
      endcase
      return r;
   endfunction

   function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
      logic [9:0] r;
      case (c)
         2'b01:   r = C_CTRL_01;
         2'b10:   r = C_CTRL_10;
         2'b11:   r = C_CTRL_11;
         default: r = C_CTRL_00;
      endcase
      return r;
   endfunction

   function automatic logic [9:0] terc4(input logic [3:0] nib);
      logic [9:0] r;
      case (nib)
         4'h0:    r = 10'b1010011100;
         4'h1:    r = 10'b1001100011;
         4'h2:    r = 10'b1011100100;
         4'h3:    r = 10'b1011100010;
         4'h4:    r = 10'b0101110001;
         4'h5:    r = 10'b0100011110;
         4'h6:    r = 10'b0110001110;
         4'h7:    r = 10'b0100111100;
         4'h8:    r = 10'b1011001100;
         4'h9:    r = 10'b0100111001;
         4'hA:    r = 10'b0110011100;
         4'hB:    r = 10'b1011000110;
         4'hC:    r = 10'b1010001110;
         4'hD:    r = 10'b1001110001;
         4'hE:    r = 10'b0101100011;
         default: r = 10'b1011000011;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage : tmds_pkg
`default_nettype wire

// File: rtl/hdmi_tmds_encoder_if.sv
`default_nettype none
// ============================================================================
// hdmi_tmds_encoder_if : pixel/control input bundle and TMDS symbol output
// Revision 1.0
// ============================================================================
interface hdmi_tmds_encoder_if #(
   parameter int NUM_CH = 3
);
   logic                  i_ce;
   logic [2:0]            i_mode;
   logic [8*NUM_CH-1:0]   i_data;
   logic [2*NUM_CH-1:0]   i_ctrl;
   logic [4*NUM_CH-1:0]   i_aux;
   logic [10*NUM_CH-1:0]  o_symbols;
   logic                  o_valid;

   modport master (
      output i_ce, i_mode, i_data, i_ctrl, i_aux,
      input  o_symbols, o_valid
   );

   modport slave (
      input  i_ce, i_mode, i_data, i_ctrl, i_aux,
      output o_symbols, o_valid
   );
endinterface : hdmi_tmds_encoder_if
`default_nettype wire

// File: rtl/hdmi_tmds_encoder_lane_enc.sv
`default_nettype none
// ============================================================================
// tmds_lane_enc : one TMDS lane, transition minimisation (A) and DC balance (B)
// Revision 1.0
// ============================================================================
module tmds_lane_enc
   import tmds_pkg::*;
#(
   parameter int LANE_IDX    = 0,
   parameter int PIPE_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ce,
   input  tmds_mode_e i_mode_a,
   input  tmds_mode_e i_mode_b,
   input  logic [7:0] i_data,
   input  logic [1:0] i_ctrl,
   input  logic [3:0] i_aux,
   output logic [9:0] o_symbol
);

   logic [8:0]                 w_qm_a;
   logic [9:0]                 w_sym_a;
   logic [8:0]                 w_qm_b;
   logic [9:0]                 w_sym_b;
   logic [3:0]                 w_n1_d;
   logic                       w_use_xnor;
   logic [3:0]                 w_n1_q;
   logic signed [C_DISP_W-1:0] w_diff;
   logic signed [C_DISP_W-1:0] w_cnt_nx;
   logic [9:0]                 w_sym_nx;
   logic signed [C_DISP_W-1:0] r_cnt;
   logic [9:0]                 r_symbol;

   always_comb begin : p_stage_a
      logic [8:0] qm;
      qm         = '0;
      w_n1_d     = popcount8(i_data);
      w_use_xnor = (w_n1_d > 4'd4) || ((w_n1_d == 4'd4) && !i_data[0]);
      qm[0]      = i_data[0];
      for (int i = 1; i < 8; i++) begin
         qm[i] = w_use_xnor ? ~(qm[i-1] ^ i_data[i]) : (qm[i-1] ^ i_data[i]);
      end
      qm[8]  = ~w_use_xnor;
      w_qm_a = qm;
   end

   // Fixed symbols are resolved in stage A so stage B only chooses video vs. this.
   always_comb begin : p_fixed_sym
      w_sym_a = ctrl_sym(i_ctrl);
      case (i_mode_a)
         MODE_TERC4:  w_sym_a = terc4(i_aux);
         MODE_VGUARD: w_sym_a = ((LANE_IDX % 2) == 0) ? C_GUARD_EVEN : C_GUARD_ODD;
         MODE_DGUARD: w_sym_a = (LANE_IDX == 0) ? terc4({2'b11, i_ctrl}) : C_GUARD_ODD;
         default:     ;
      endcase
   end

   if (PIPE_STAGES == 2) begin : g_pipe2
      logic [8:0] r_qm_b;
      logic [9:0] r_sym_b;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_qm_b  <= '0;
            r_sym_b <= C_CTRL_00;
         end else if (i_ce) begin
            r_qm_b  <= w_qm_a;
            r_sym_b <= w_sym_a;
         end
      end

      assign w_qm_b  = r_qm_b;
      assign w_sym_b = r_sym_b;
   end else begin : g_pipe1
      assign w_qm_b  = w_qm_a;
      assign w_sym_b = w_sym_a;
   end

   // Disparity arithmetic wraps modulo 2^C_DISP_W; legal streams stay in range.
   always_comb begin : p_stage_b
      w_n1_q   = popcount8(w_qm_b[7:0]);
      w_diff   = $signed({w_n1_q, 1'b0}) - 5'sd8;
      w_sym_nx = w_sym_b;
      w_cnt_nx = '0;
      if (i_mode_b == MODE_VIDEO) begin
         if ((r_cnt == 5'sd0) || (w_n1_q == 4'd4)) begin
            w_sym_nx = {~w_qm_b[8], w_qm_b[8], w_qm_b[8] ? w_qm_b[7:0] : ~w_qm_b[7:0]};
            w_cnt_nx = w_qm_b[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
         end else if ((!r_cnt[C_DISP_W-1] && (w_n1_q > 4'd4)) ||
                      ( r_cnt[C_DISP_W-1] && (w_n1_q < 4'd4))) begin
            w_sym_nx = {1'b1, w_qm_b[8], ~w_qm_b[7:0]};
            w_cnt_nx = r_cnt + (w_qm_b[8] ? 5'sd2 : 5'sd0) - w_diff;
         end else begin
            w_sym_nx = {1'b0, w_qm_b[8], w_qm_b[7:0]};
            w_cnt_nx = r_cnt - (w_qm_b[8] ? 5'sd0 : 5'sd2) + w_diff;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_symbol <= C_CTRL_00;
         r_cnt    <= '0;
      end else if (i_ce) begin
         r_symbol <= w_sym_nx;
         r_cnt    <= w_cnt_nx;
      end
   end

   assign o_symbol = r_symbol;

endmodule : tmds_lane_enc
`default_nettype wire

// File: rtl/hdmi_tmds_encoder.sv
`default_nettype none
// ============================================================================
// hdmi_tmds_encoder : NUM_CH-lane TMDS encoder with mode pipeline and valid flag
// Revision 1.0
// ============================================================================
module hdmi_tmds_encoder
   import tmds_pkg::*;
#(
   parameter int NUM_CH      = 3,
   parameter int PIPE_STAGES = 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   hdmi_tmds_encoder_if.slave  bus
);

   tmds_mode_e             w_mode_a;
   tmds_mode_e             w_mode_b;
   logic                   w_valid_b;
   logic                   r_valid;
   logic [10*NUM_CH-1:0]   w_symbols;

   assign w_mode_a = norm_mode(bus.i_mode);

   // Mode travels with its data so a mode switch lands on the exact symbol.
   if (PIPE_STAGES == 2) begin : g_mode_pipe2
      tmds_mode_e r_mode_b;
      logic       r_valid_a;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_mode_b  <= MODE_CTRL;
            r_valid_a <= 1'b0;
         end else if (bus.i_ce) begin
            r_mode_b  <= w_mode_a;
            r_valid_a <= 1'b1;
         end
      end

      assign w_mode_b  = r_mode_b;
      assign w_valid_b = r_valid_a;
   end else begin : g_mode_pipe1
      assign w_mode_b  = w_mode_a;
      assign w_valid_b = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
      end else if (bus.i_ce) begin
         r_valid <= w_valid_b;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      tmds_lane_enc #(
         .LANE_IDX    (k),
         .PIPE_STAGES (PIPE_STAGES)
      ) u_lane (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .i_ce     (bus.i_ce),
         .i_mode_a (w_mode_a),
         .i_mode_b (w_mode_b),
         .i_data   (bus.i_data[8*k +: 8]),
         .i_ctrl   (bus.i_ctrl[2*k +: 2]),
         .i_aux    (bus.i_aux[4*k +: 4]),
         .o_symbol (w_symbols[10*k +: 10])
      );
   end

   assign bus.o_symbols = w_symbols;
   assign bus.o_valid   = r_valid;

endmodule : hdmi_tmds_encoder
`default_nettype wire

// File: doc/hdmi_tmds_encoder.md
HDMI_TMDS_ENCODER -- requirements
Module: hdmi_tmds_encoder

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent TMDS lanes; legal range 1..4.
REQ-002 Parameter PIPE_STAGES, default 2: latency from an i_ce-qualified input to o_symbols; legal values 1 or 2.
REQ-003 i_clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1: reset, asynchronous, active-low.
REQ-005 i_ce  input  1: clock enable; the input is sampled and the pipeline advances only when high.
REQ-006 i_mode  input  3: lane mode per the package enum: CTRL=0, VIDEO=1, TERC4=2, VGUARD=3, DGUARD=4; values 5..7 are treated as CTRL.
REQ-007 i_data  input  8*NUM_CH: video byte per lane; lane k uses bits [8k+7:8k].
REQ-008 i_ctrl  input  2*NUM_CH: control pair per lane ({c1,c0}); lane 0 carries {vsync,hsync}.
REQ-009 i_aux  input  4*NUM_CH: TERC4 nibble per lane.
REQ-010 o_symbols  output  10*NUM_CH: registered 10-bit TMDS symbol per lane; lane k uses bits [10k+9:10k]; bit 0 is transmitted first.
REQ-011 o_valid  output  1: high once o_symbols holds a symbol derived from a sampled input since reset.

Function
REQ-012 VIDEO, stage A: per lane, count N1 of the data; select XOR when N1<4 or (N1==4 and d[0]==1), else XNOR; q_m[8]=1 for XOR and 0 for XNOR.
REQ-013 VIDEO, stage B: DC balance uses a per-lane signed 5-bit running disparity cnt (range -16..+15), which shall never overflow for legal input.
REQ-014 If cnt==0 or N1(q_m[7:0])==N0: out={~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}; cnt += q_m8 ? (N1-N0) : (N0-N1).
REQ-015 Else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out={1, q_m8, ~q_m[7:0]}; cnt += 2*q_m8 + (N0-N1).
REQ-016 Otherwise: out={0, q_m8, q_m[7:0]}; cnt += -2*(~q_m8) + (N1-N0).
REQ-017 CTRL: {c1,c0} 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011.
REQ-018 TERC4: 16-entry table per HDMI 1.4 (0000->1010011100 ... 1111->1011000011).
REQ-019 VGUARD: lanes 0 and 2 send 1011001100; lane 1 and lane 3 send 0100110011.
REQ-020 DGUARD: lane 0 sends TERC4 of {1,1,vsync,hsync}; all other lanes send 0100110011.
REQ-021 Any non-VIDEO mode sampled with i_ce=1 clears cnt to 0 for every lane.
REQ-022 i_ce=0: o_symbols, o_valid and cnt all hold; no state advances.
REQ-023 Latency: a sample taken on edge n appears on o_symbols after PIPE_STAGES i_ce-qualified edges. For PIPE_STAGES=1, stages A and B are combinational into one register.
REQ-024 i_mode is carried through the pipeline alongside the data, so a mode change takes effect on the exact symbol it was sampled with; there are no bubbles.
REQ-025 o_valid rises on the same edge that the first sampled input reaches o_symbols.

Reset
REQ-026 While i_rst_n=0, each lane's o_symbols = 1101010100 (CTRL 00), o_valid=0, all cnt=0, and pipeline mode registers = CTRL, all applied asynchronously.
REQ-027 On deassertion, the first i_ce edge samples normally; a reset mid-stream discards in-flight symbols.

Structure
REQ-028 Package tmds_pkg holds: the mode enum, the CTRL/TERC4/guard symbol constants, and the disparity width.
REQ-029 Sub-module tmds_lane_enc (one lane, stages A/B, cnt) is instantiated NUM_CH times by a generate loop; the top level holds o_valid and the mode pipeline.

Verification
REQ-030 Reset, VIDEO 0x00 on lane 0 for 4 ce cycles -> symbols 0x100, 0x3FF, 0x100, 0x3FF; cnt -8, +2, -6, +4.
REQ-031 CTRL sweep of {vsync,hsync}=00,01,10,11 -> lane 0 emits 0x354, 0x0AB, 0x154, 0x2AB at latency PIPE_STAGES.
REQ-032 Random VIDEO stream of 10k bytes -> output matches the reference model, each symbol decodes back to the input byte, and |cnt| never exceeds 10.
REQ-033 VGUARD then DGUARD with {vsync,hsync}=11 -> lane 1 emits 0x133 in both modes; lane 0 emits 0x2CC, then TERC4(1111).
REQ-034 Toggle i_ce at 1/3 rate and pulse i_rst_n mid-stream -> outputs hold while ce=0, and on reset o_valid=0 and o_symbols=0x354 immediately (asynchronously).
REQ-035 Switch VIDEO->TERC4->VIDEO -> first VIDEO symbol after the switch is encoded from cnt=0.
